spi_master_ctrl: RTL

SPI transaction sequencer that drives the existing SPI slave + RAM subsystem from a parallel request port. It turns one request (write-address, write-data, read-address, read-data) into a complete SPI frame on `SS_n`/`MOSI`, captures the 8-bit read byte from `MISO`, and returns it on a response port. It sits between the system-side requester and the SPI slave. It shares the slave's clock, so SPI bits advance once per `clk` cycle.

---
 rtl/spi_master_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI transaction sequencer: turns one parallel request into a complete SPI frame
// for the slave/RAM subsystem and returns read-data bytes captured from MISO.
module spi_master_ctrl #(
  parameter int TURNAROUND = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_CMD, S_WORD, S_TURN, S_RX, S_END, S_ERR
  } state_t;

  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  state_t     state, state_n;
  logic [9:0] shift_word, shift_word_n;
  logic [1:0] op, op_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [2:0] turn_cnt, turn_cnt_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       rd_addr_pending, rd_addr_pending_n;
  logic       ss_n_n, mosi_n, req_ready_n, busy_n, rsp_valid_n, rsp_err_n;
  logic [7:0] rsp_data_n;
  logic       accept;

  // Outputs are registered from the next state so every pin changes on the edge
  // that enters the state it belongs to.
  always_comb begin
    state_n           = state;
    shift_word_n      = shift_word;
    op_n              = op;
    bit_cnt_n         = bit_cnt;
    turn_cnt_n        = turn_cnt;
    rx_shift_n        = rx_shift;
    rd_addr_pending_n = rd_addr_pending;
    rsp_data_n        = rsp_data;
    accept            = req_valid && req_ready;

    case (state)
      S_IDLE: begin
        if (accept) begin
          op_n         = req_op;
          shift_word_n = {req_op, (req_op == OP_RD_DATA) ? 8'h00 : req_data};
          bit_cnt_n    = '0;
          turn_cnt_n   = '0;
          state_n      = (req_op == OP_RD_DATA && !rd_addr_pending) ? S_ERR : S_START;
        end
      end
      S_START: state_n = S_CMD;
      S_CMD: begin
        state_n   = S_WORD;
        bit_cnt_n = '0;
      end
      S_WORD: begin
        if (bit_cnt == 4'd9) begin
          bit_cnt_n = '0;
          if (op == OP_RD_DATA) begin
            state_n = S_TURN;
          end else begin
            state_n = S_END;
            if (op == OP_RD_ADDR) rd_addr_pending_n = 1'b1;
          end
        end else begin
          bit_cnt_n    = bit_cnt + 4'd1;
          shift_word_n = {shift_word[8:0], 1'b0};
        end
      end
      S_TURN: begin
        if (turn_cnt == 3'(TURNAROUND - 1)) begin
          state_n    = S_RX;
          turn_cnt_n = '0;
          bit_cnt_n  = '0;
        end else begin
          turn_cnt_n = turn_cnt + 3'd1;
        end
      end
      S_RX: begin
        rx_shift_n = {rx_shift[6:0], MISO};
        if (bit_cnt == 4'd7) begin
          state_n           = S_END;
          bit_cnt_n         = '0;
          rsp_data_n        = rx_shift_n;
          rd_addr_pending_n = 1'b0;
        end else begin
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      S_END:   state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    ss_n_n      = !(state_n inside {S_START, S_CMD, S_WORD, S_TURN, S_RX});
    mosi_n      = (state_n == S_CMD)  ? op_n[1] :
                  (state_n == S_WORD) ? shift_word_n[9] : 1'b0;
    req_ready_n = (state_n == S_IDLE);
    busy_n      = !req_ready_n;
    rsp_valid_n = (state_n == S_END && op_n == OP_RD_DATA) || (state_n == S_ERR);
    rsp_err_n   = (state_n == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      shift_word      <= '0;
      op              <= '0;
      bit_cnt         <= '0;
      turn_cnt        <= '0;
      rx_shift        <= '0;
      rd_addr_pending <= 1'b0;
      SS_n            <= 1'b1;
      MOSI            <= 1'b0;
      req_ready       <= 1'b0;
      busy            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_data        <= '0;
    end else begin
      state           <= state_n;
      shift_word      <= shift_word_n;
      op              <= op_n;
      bit_cnt         <= bit_cnt_n;
      turn_cnt        <= turn_cnt_n;
      rx_shift        <= rx_shift_n;
      rd_addr_pending <= rd_addr_pending_n;
      SS_n            <= ss_n_n;
      MOSI            <= mosi_n;
      req_ready       <= req_ready_n;
      busy            <= busy_n;
      rsp_valid       <= rsp_valid_n;
      rsp_err         <= rsp_err_n;
      rsp_data        <= rsp_data_n;
    end
  end

endmodule
